gb_timer: RTL
=============

Name: gb_timer

Overview:
Game Boy DIV/TIMA/TMA/TAC timer peripheral on the CPU memory bus at FF04–FF07.
- Runs from the same clock as the CPU.
- Produces the timer_int interrupt request that the top level routes to the interrupt logic.
- The memory map muxes its read data onto the CPU data-in path whenever cpu_sel is high.

Parameters:
RELOAD_DELAY, 4, clocks between TIMA overflow (TIMA reads 00) and reload from TMA plus interrupt; must be >= 1.
BASE_ADDR, 16'hFF04, address of DIV; TIMA, TMA and TAC follow at +1, +2 and +3.

Ports:
clock  in  1  system clock; one tick = one Game Boy T-cycle.
reset  in  1  asynchronous, active-low reset.
cpu_addr  in  16  CPU bus address.
cpu_wren  in  1  CPU write strobe; one write per asserted clock.
cpu_data_in  in  8  CPU write data.
cpu_data_out  out  8  read data for the addressed register (combinational).
cpu_sel  out  1  high when cpu_addr is in BASE_ADDR..BASE_ADDR+3 (combinational).
timer_int  out  1  one-clock pulse requesting the timer interrupt.

Behaviour:
State:
- div_cnt: 16-bit internal counter.
- tima, tma: 8-bit registers.
- tac: 3-bit register (bit 2 = enable, bits 1:0 = select).
- FSM: RUN, OVF (overflow delay).
- ovf_cnt: delay counter sized for RELOAD_DELAY.
- prev_tick: 1-bit edge-detect register.

Reset (reset low, asynchronous):
- div_cnt = 0, tima = 0, tma = 0, tac = 0, prev_tick = 0.
- FSM = RUN, timer_int = 0.

Register reads:
- DIV returns div_cnt[15:8].
- TIMA returns tima; TMA returns tma.
- TAC returns {5'b11111, tac}.
- When cpu_sel is low, cpu_data_out = 8'hFF.

div_cnt:
- Increments by 1 every clock, wrapping 16'hFFFF -> 0.
- Any write to DIV (data ignored) sets div_cnt = 0 on that edge instead of incrementing.

Tick source:
- Selected bit: select 00 -> div_cnt[9], 01 -> [3], 10 -> [5], 11 -> [7].
- tick = tac[2] AND selected bit of the post-update div_cnt; prev_tick <= tick every clock.
- A TIMA increment event is prev_tick = 1 and tick = 0 (falling edge).
- The falling-edge rule also applies to edges caused by a DIV write or a TAC write (enable clear or select change). These glitch increments are required behaviour.

RUN state:
- Increment event with tima < FF: tima <= tima + 1.
- Increment event with tima = FF: tima <= 00, ovf_cnt <= RELOAD_DELAY - 1, go to OVF.
- A CPU write to TIMA in the same clock as an increment event wins; no increment, no overflow.

OVF state:
- tima holds 00 and increment events are ignored.
- Each clock: if ovf_cnt = 0, then tima <= tma, timer_int = 1 for this clock, go to RUN. Otherwise ovf_cnt decrements.
- A CPU write to TIMA before the reload clock cancels the overflow: tima takes the written value, no interrupt, go to RUN.
- A CPU write to TIMA on the reload clock is ignored; tima gets tma.
- A CPU write to TMA on the reload clock: tima gets the newly written TMA value.

Other rules:
- TMA and TAC writes take effect on the next edge; only tac gets bits [2:0].
- timer_int is registered, high for exactly one clock per overflow; never asserted outside the reload clock.
- Reset asserted mid-OVF aborts the overflow: no interrupt is emitted after reset is released.

Test Plan:
1. Release reset, no writes, 1024 clocks -> DIV reads 8'h04, TIMA reads 00, TAC reads 8'hF8, timer_int never high.
2. TAC = 3'b101, TIMA = 0 -> TIMA = 1 after 16 clocks; TIMA = 10 after 160 clocks.
3. TAC = 3'b101, TMA = 8'hAB, TIMA = 8'hFE -> after 2 increments TIMA reads 00 for 4 clocks, then reads AB, with timer_int high exactly 1 clock.
4. Same overflow setup, then write TIMA = 8'h55 two clocks into OVF -> TIMA = 55, no timer_int. Separately, write TMA = 8'h12 on the reload clock -> TIMA = 12 and timer_int pulses.
5. TAC = 3'b100 with div_cnt[9] = 1, then write DIV -> TIMA increments by 1 immediately. Writing TAC = 3'b000 while bit 9 = 1 also increments TIMA by 1.
6. Pull reset low during OVF -> all registers read 0 (TAC reads F8) and no timer_int after release. Read at 16'hFF08 -> cpu_sel = 0, cpu_data_out = FF.

Source files
------------

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer block with a delayed TIMA reload and a one-clock interrupt pulse.
// Registers sit at BASE_ADDR..BASE_ADDR+3 on the CPU bus. Reads are combinational.
module gb_timer #(
   parameter int unsigned RELOAD_DELAY = 4,
   parameter logic [15:0] BASE_ADDR    = 16'hFF04
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wren,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_sel,
   output logic        timer_int
);

   localparam int unsigned      CNT_W    = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELOAD_DELAY - 1);

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_OVF = 1'b1;

   // Bit of the divider that clocks TIMA for each TAC select code.
   function automatic int unsigned tap_index(input int unsigned sel);
      case (sel)
         0:       tap_index = 9;
         1:       tap_index = 3;
         2:       tap_index = 5;
         default: tap_index = 7;
      endcase
   endfunction

   logic [15:0]      div_q, div_d;
   logic [7:0]       tima_q, tima_d;
   logic [7:0]       tma_q, tma_d;
   logic [2:0]       tac_q, tac_d;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
   logic             prev_tick_q, tick_d;
   logic             int_q, int_d;

   logic [16:0] addr_off;
   logic [1:0]  reg_idx;
   logic        wr_div, wr_tima, wr_tma, wr_tac;
   logic [3:0]  tap_bits;
   logic        inc_evt;

   // Unsigned 17-bit offset: addresses below BASE_ADDR wrap to a huge value and fail the range test.
   assign addr_off = {1'b0, cpu_addr} - {1'b0, BASE_ADDR};
   assign cpu_sel  = (addr_off < 17'd4);
   assign reg_idx  = addr_off[1:0];

   assign wr_div  = cpu_wren && cpu_sel && (reg_idx == 2'd0);
   assign wr_tima = cpu_wren && cpu_sel && (reg_idx == 2'd1);
   assign wr_tma  = cpu_wren && cpu_sel && (reg_idx == 2'd2);
   assign wr_tac  = cpu_wren && cpu_sel && (reg_idx == 2'd3);

   always_comb begin
      div_d = wr_div ? 16'h0000 : div_q + 16'h0001;
      tac_d = wr_tac ? cpu_data_in[2:0] : tac_q;
      tma_d = wr_tma ? cpu_data_in : tma_q;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_tap
         assign tap_bits[gi] = div_d[tap_index(gi)];
      end
   endgenerate

   // Tick is formed from post-write DIV and TAC, so DIV and TAC writes can produce a falling edge.
   assign tick_d  = tac_d[2] & tap_bits[tac_d[1:0]];
   assign inc_evt = prev_tick_q & ~tick_d;

   always_comb begin
      tima_d    = tima_q;
      state_d   = state_q;
      ovf_cnt_d = ovf_cnt_q;
      int_d     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (wr_tima) begin
               tima_d = cpu_data_in;
            end else if (inc_evt) begin
               if (tima_q == 8'hFF) begin
                  tima_d    = 8'h00;
                  ovf_cnt_d = CNT_LOAD;
                  state_d   = ST_OVF;
               end else begin
                  tima_d = tima_q + 8'h01;
               end
            end
         end
         ST_OVF: begin
            // The reload clock beats a concurrent TIMA write and sees a concurrent TMA write.
            if (ovf_cnt_q == '0) begin
               tima_d  = tma_d;
               int_d   = 1'b1;
               state_d = ST_RUN;
            end else if (wr_tima) begin
               tima_d  = cpu_data_in;
               state_d = ST_RUN;
            end else begin
               ovf_cnt_d = ovf_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_q       <= 16'h0000;
         tima_q      <= 8'h00;
         tma_q       <= 8'h00;
         tac_q       <= 3'b000;
         state_q     <= ST_RUN;
         ovf_cnt_q   <= '0;
         prev_tick_q <= 1'b0;
         int_q       <= 1'b0;
      end else begin
         div_q       <= div_d;
         tima_q      <= tima_d;
         tma_q       <= tma_d;
         tac_q       <= tac_d;
         state_q     <= state_d;
         ovf_cnt_q   <= ovf_cnt_d;
         prev_tick_q <= tick_d;
         int_q       <= int_d;
      end
   end

   assign timer_int = int_q;

   always_comb begin
      cpu_data_out = 8'hFF;
      if (cpu_sel) begin
         case (reg_idx)
            2'd0:    cpu_data_out = div_q[15:8];
            2'd1:    cpu_data_out = tima_q;
            2'd2:    cpu_data_out = tma_q;
            default: cpu_data_out = {5'b11111, tac_q};
         endcase
      end
   end

endmodule
